// File: rtl/scan_decoder_fifo_pkg.sv
// scan_pkg: shared types and helpers for the PS/2 set-2 digit decoder.
//   scan_state_e : prefix-tracking FSM states
//   SC_BREAK/SC_EXT : release and extended prefix bytes
//   decode_scan() : byte -> {hit, value[3:0]} for top-row, keypad and hex keys
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } scan_state_e;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  // Keypad and hex entries report a hit only when their class is enabled;
  // the value field is meaningless without a hit.
  function automatic logic [4:0] decode_scan(input logic [7:0] sc,
                                             input logic       keypad_en,
                                             input logic       hex_mode);
    logic [4:0] res;
    res = 5'd0;
    case (sc)
      8'h45: res = {1'b1, 4'd0};
      8'h16: res = {1'b1, 4'd1};
      8'h1E: res = {1'b1, 4'd2};
      8'h26: res = {1'b1, 4'd3};
      8'h25: res = {1'b1, 4'd4};
      8'h2E: res = {1'b1, 4'd5};
      8'h36: res = {1'b1, 4'd6};
      8'h3D: res = {1'b1, 4'd7};
      8'h3E: res = {1'b1, 4'd8};
      8'h46: res = {1'b1, 4'd9};
      8'h70: res = {keypad_en, 4'd0};
      8'h69: res = {keypad_en, 4'd1};
      8'h72: res = {keypad_en, 4'd2};
      8'h7A: res = {keypad_en, 4'd3};
      8'h6B: res = {keypad_en, 4'd4};
      8'h73: res = {keypad_en, 4'd5};
      8'h74: res = {keypad_en, 4'd6};
      8'h6C: res = {keypad_en, 4'd7};
      8'h75: res = {keypad_en, 4'd8};
      8'h7D: res = {keypad_en, 4'd9};
      8'h1C: res = {hex_mode, 4'hA};
      8'h32: res = {hex_mode, 4'hB};
      8'h21: res = {hex_mode, 4'hC};
      8'h23: res = {hex_mode, 4'hD};
      8'h24: res = {hex_mode, 4'hE};
      8'h2B: res = {hex_mode, 4'hF};
      default: res = 5'd0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/scan_decoder_fifo_if.sv
// scan_decoder_fifo_if: byte input strobe, control, and valid/ready digit
// output of the scan decoder.
//   master : drives code_valid, code, enable, flush, num_ready
//   slave  : drives num_valid, num, count, overflow
interface scan_decoder_fifo_if #(
  parameter int CNT_W = 4
);
  logic             code_valid;
  logic [7:0]       code;
  logic             enable;
  logic             flush;
  logic             num_valid;
  logic [3:0]       num;
  logic             num_ready;
  logic [CNT_W-1:0] count;
  logic             overflow;

  modport master (
    output code_valid, code, enable, flush, num_ready,
    input  num_valid, num, count, overflow
  );

  modport slave (
    input  code_valid, code, enable, flush, num_ready,
    output num_valid, num, count, overflow
  );
endinterface

// File: rtl/scan_decoder_fifo_sync_fifo.sv
// sync_fifo: show-ahead FIFO with a registered head.
//   push/din  : write when not full (or when popping in the same cycle)
//   pop       : ignored when empty
//   flush     : empties the FIFO; dout keeps its last value
//   dout      : registered head entry, valid while !empty
//   full/empty/count : occupancy
module sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] rd_nxt;
  logic [CNT_W-1:0]  cnt_q;
  logic [WIDTH-1:0]  head_q;
  logic              do_push;
  logic              do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);
  assign rd_nxt  = rd_ptr + 1'b1;
  assign dout    = head_q;
  assign count   = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_nxt;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      // Head tracks the oldest entry: the next stored one after a pop, or
      // the incoming word when it lands in an empty (or emptying) FIFO.
      if (do_pop) begin
        if (cnt_q > CNT_W'(1)) head_q <= mem[rd_nxt];
        else if (do_push)      head_q <= din;
      end else if (empty && do_push) begin
        head_q <= din;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/scan_decoder_fifo.sv
// scan_decoder_fifo: tracks PS/2 set-2 make/break/extended prefixes, decodes
// released digit keys and queues them in a DEPTH-entry show-ahead FIFO.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : code_valid/code in, enable/flush control, num_valid/num/
//              num_ready output handshake, count and sticky overflow
//
// state   | meaning
// IDLE    | no prefix pending
// EXT     | E0 seen, waiting for extended byte
// BRK     | F0 seen, next non-prefix byte is a released key (decoded)
// EXT_BRK | E0 F0 seen, next non-prefix byte is discarded
module scan_decoder_fifo
  import scan_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int KEYPAD_EN = 1,
  parameter int HEX_MODE  = 0,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input logic                clk,
  input logic                rst,
  scan_decoder_fifo_if.slave bus
);
  scan_state_e state;
  scan_state_e state_nxt;
  logic [4:0]  dec;
  logic        push;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic        ovf_q;
  logic        is_prefix;

  assign is_prefix = (bus.code == SC_BREAK) || (bus.code == SC_EXT);
  assign pop       = !fifo_empty && bus.num_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            state <= IDLE;
    else if (bus.flush) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.code_valid) begin
      case (state)
        IDLE: begin
          if (bus.code == SC_EXT)        state_nxt = EXT;
          else if (bus.code == SC_BREAK) state_nxt = BRK;
          else                           state_nxt = IDLE;
        end
        EXT: begin
          if (bus.code == SC_BREAK)    state_nxt = EXT_BRK;
          else if (bus.code == SC_EXT) state_nxt = EXT;
          else                         state_nxt = IDLE;
        end
        BRK: begin
          if (bus.code == SC_BREAK)    state_nxt = BRK;
          else if (bus.code == SC_EXT) state_nxt = EXT;
          else                         state_nxt = IDLE;
        end
        EXT_BRK: begin
          if (is_prefix) state_nxt = EXT_BRK;
          else           state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    dec  = decode_scan(bus.code, KEYPAD_EN != 0, HEX_MODE != 0);
    push = bus.code_valid && (state == BRK) && !is_prefix && dec[4] && bus.enable;
  end

  // A simultaneous pop makes room, so only a push against a full FIFO with
  // no pop is a drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            ovf_q <= 1'b0;
    else if (bus.flush)                 ovf_q <= 1'b0;
    else if (push && fifo_full && !pop) ovf_q <= 1'b1;
  end

  sync_fifo #(
    .WIDTH (4),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.flush),
    .din   (dec[3:0]),
    .dout  (bus.num),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (bus.count)
  );

  assign bus.num_valid = !fifo_empty;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_scan_decoder_fifo.sv
// Two DUTs share one stimulus stream: dut_a decodes keypad and hex keys,
// dut_b decodes top-row digits only. A queue-based reference model per DUT
// predicts every output after every clock edge.
module tb_scan_decoder_fifo;
  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  scan_decoder_fifo_if #(.CNT_W(CNT_W)) bus_a ();
  scan_decoder_fifo_if #(.CNT_W(CNT_W)) bus_b ();

  scan_decoder_fifo #(.DEPTH(DEPTH), .KEYPAD_EN(1), .HEX_MODE(1), .CNT_W(CNT_W))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  scan_decoder_fifo #(.DEPTH(DEPTH), .KEYPAD_EN(0), .HEX_MODE(0), .CNT_W(CNT_W))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  logic [7:0] top_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] kp_codes  [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
  logic [7:0] hex_codes [6]  = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};

  int n_checks = 0;
  int n_fail   = 0;

  // model state, index 0 = dut_a, 1 = dut_b
  int mq [2][$];
  bit m_ext [2];
  bit m_brk [2];
  bit m_ovf [2];
  int m_num [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_dec(int k, logic [7:0] sc);
    for (int i = 0; i < 10; i++) if (top_codes[i] == sc) return i;
    if (k == 0) begin
      for (int i = 0; i < 10; i++) if (kp_codes[i] == sc) return i;
      for (int i = 0; i < 6; i++)  if (hex_codes[i] == sc) return 10 + i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      m_ext[k] = 1'b0;
      m_brk[k] = 1'b0;
      m_ovf[k] = 1'b0;
      m_num[k] = 0;
    end
  endtask

  // Rules: a byte after F0 (with no pending E0) is a release and may decode;
  // E0 marks the sequence extended; any non-prefix byte ends the sequence.
  task automatic model_step(input int k, input logic cv, input logic [7:0] c,
                            input logic en, input logic fl, input logic rdy);
    bit pop;
    int d;
    pop = (mq[k].size() > 0) && rdy;
    if (fl) begin
      mq[k].delete();
      m_ovf[k] = 1'b0;
      m_ext[k] = 1'b0;
      m_brk[k] = 1'b0;
    end else begin
      d = -1;
      if (cv) begin
        if (c == 8'hE0) begin
          if (!m_ext[k]) m_brk[k] = 1'b0;
          m_ext[k] = 1'b1;
        end else if (c == 8'hF0) begin
          m_brk[k] = 1'b1;
        end else begin
          if (m_brk[k] && !m_ext[k]) d = model_dec(k, c);
          m_ext[k] = 1'b0;
          m_brk[k] = 1'b0;
        end
      end
      if (pop) void'(mq[k].pop_front());
      if (d >= 0 && en) begin
        if (mq[k].size() < DEPTH) mq[k].push_back(d);
        else m_ovf[k] = 1'b1;
      end
    end
    if (mq[k].size() > 0) m_num[k] = mq[k][0];
  endtask

  task automatic compare_all(input int k);
    logic             v;
    logic [3:0]       n;
    logic [CNT_W-1:0] c;
    logic             o;
    string            p;
    if (k == 0) begin
      v = bus_a.num_valid; n = bus_a.num; c = bus_a.count; o = bus_a.overflow; p = "a";
    end else begin
      v = bus_b.num_valid; n = bus_b.num; c = bus_b.count; o = bus_b.overflow; p = "b";
    end
    check({p, ".num_valid"}, 32'(v), 32'(mq[k].size() > 0));
    check({p, ".count"},     32'(c), 32'(mq[k].size()));
    check({p, ".overflow"},  32'(o), 32'(m_ovf[k]));
    check({p, ".num"},       32'(n), 32'(m_num[k]));
  endtask

  task automatic step(input logic cv, input logic [7:0] c, input logic en,
                      input logic fl, input logic rdy);
    bus_a.code_valid = cv; bus_b.code_valid = cv;
    bus_a.code = c;        bus_b.code = c;
    bus_a.enable = en;     bus_b.enable = en;
    bus_a.flush = fl;      bus_b.flush = fl;
    bus_a.num_ready = rdy; bus_b.num_ready = rdy;
    model_step(0, cv, c, en, fl, rdy);
    model_step(1, cv, c, en, fl, rdy);
    @(posedge clk);
    #1;
    compare_all(0);
    compare_all(1);
  endtask

  task automatic send(input logic [7:0] c, input logic en, input logic rdy);
    step(1'b1, c, en, 1'b0, rdy);
  endtask

  task automatic do_flush();
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    model_reset();
    #2;
    compare_all(0);
    compare_all(1);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    logic cv, en, rdy, fl;
    int r;
    rst = 1'b1;
    bus_a.code_valid = 1'b0; bus_b.code_valid = 1'b0;
    bus_a.code = 8'h00;      bus_b.code = 8'h00;
    bus_a.enable = 1'b1;     bus_b.enable = 1'b1;
    bus_a.flush = 1'b0;      bus_b.flush = 1'b0;
    bus_a.num_ready = 1'b0;  bus_b.num_ready = 1'b0;
    model_reset();
    #12;
    compare_all(0);
    compare_all(1);
    check("rst.num", 32'(bus_a.num), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // make, release of '1'
    send(8'h16, 1, 0); send(8'hF0, 1, 0); send(8'h16, 1, 0);
    check("tp1.count", 32'(bus_a.count), 32'd1);
    check("tp1.valid", 32'(bus_a.num_valid), 32'd1);
    check("tp1.num",   32'(bus_a.num), 32'd1);

    // extended release discarded, keypad release depends on KEYPAD_EN
    do_flush();
    send(8'hE0, 1, 0); send(8'hF0, 1, 0); send(8'h70, 1, 0);
    check("tp2.ext_count", 32'(bus_a.count), 32'd0);
    send(8'hF0, 1, 0); send(8'h70, 1, 0);
    check("tp2.kp_count", 32'(bus_a.count), 32'd1);
    check("tp2.kp_num",   32'(bus_a.num), 32'd0);
    check("tp2.nokp_count", 32'(bus_b.count), 32'd0);

    // hex keys, then drain
    do_flush();
    send(8'hF0, 1, 0); send(8'h1C, 1, 0); send(8'hF0, 1, 0); send(8'h2B, 1, 0);
    check("tp3.count", 32'(bus_a.count), 32'd2);
    check("tp3.head",  32'(bus_a.num), 32'hA);
    check("tp3.nohex", 32'(bus_b.count), 32'd0);
    step(0, 8'h00, 1, 0, 1);
    check("tp3.second", 32'(bus_a.num), 32'hF);
    step(0, 8'h00, 1, 0, 1);
    check("tp3.drained", 32'(bus_a.num_valid), 32'd0);

    // overflow, then full with simultaneous pop
    do_flush();
    for (int i = 0; i < 9; i++) begin
      send(8'hF0, 1, 0); send(top_codes[i], 1, 0);
    end
    check("tp4.count", 32'(bus_a.count), 32'd8);
    check("tp4.ovf",   32'(bus_a.overflow), 32'd1);
    send(8'hF0, 1, 0); send(top_codes[3], 1, 1);
    check("tp4.full_pp_count", 32'(bus_a.count), 32'd8);
    check("tp4.full_pp_head",  32'(bus_a.num), 32'd1);
    do_flush();
    for (int i = 0; i < 8; i++) begin
      send(8'hF0, 1, 0); send(top_codes[i], 1, 0);
    end
    send(8'hF0, 1, 0); send(top_codes[9], 1, 1);
    check("tp4.no_new_ovf", 32'(bus_a.overflow), 32'd0);
    check("tp4.pp_count",   32'(bus_a.count), 32'd8);

    // enable gating and flush
    do_flush();
    send(8'hF0, 0, 0); send(8'h45, 0, 0);
    check("tp5.disabled", 32'(bus_a.count), 32'd0);
    send(8'hF0, 1, 0); send(8'h46, 1, 0);
    check("tp5.num9", 32'(bus_a.num), 32'd9);
    send(8'hF0, 1, 0); send(8'h16, 1, 0); send(8'hF0, 1, 0); send(8'h1E, 1, 0);
    check("tp5.three", 32'(bus_a.count), 32'd3);
    do_flush();
    check("tp5.fl_count", 32'(bus_a.count), 32'd0);
    check("tp5.fl_valid", 32'(bus_a.num_valid), 32'd0);
    check("tp5.fl_ovf",   32'(bus_a.overflow), 32'd0);
    check("tp5.fl_num",   32'(bus_a.num), 32'd9);

    // reset mid-sequence
    send(8'hF0, 1, 0);
    reset_pulse();
    send(8'h26, 1, 0);
    check("tp6.make_after_rst", 32'(bus_a.count), 32'd0);
    send(8'hF0, 1, 0); send(8'h26, 1, 0);
    check("tp6.num3", 32'(bus_a.num), 32'd3);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      cv = ($urandom_range(0, 3) != 0);
      r  = $urandom_range(0, 9);
      if (r <= 2)      b = 8'hF0;
      else if (r == 3) b = 8'hE0;
      else if (r <= 6) b = top_codes[$urandom_range(0, 9)];
      else if (r == 7) b = kp_codes[$urandom_range(0, 9)];
      else if (r == 8) b = hex_codes[$urandom_range(0, 5)];
      else             b = 8'($urandom_range(0, 255));
      en  = ($urandom_range(0, 7) != 0);
      rdy = ($urandom_range(0, 2) == 0);
      fl  = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 599) == 0) reset_pulse();
      step(cv, b, en, fl, rdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_decoder_fifo.md
Name: scan_decoder_fifo

Overview:
Parametrised successor to the single-digit scan-code decoder. It consumes a byte stream of PS/2 set-2 scan codes and tracks make, break (F0) and extended (E0) prefixes with an explicit FSM. On each key release it decodes digits (top row, optional keypad, optional hex letters) and queues them in a DEPTH-entry FIFO. The FIFO has a valid/ready output. The block sits between the PS/2 receiver and the numeric-entry/display logic.

Parameters:
DEPTH, 8, FIFO entries; power of two, at least 2
KEYPAD_EN, 1, 1 = numeric keypad codes also decode to digits
HEX_MODE, 0, 1 = keys A–F decode to values 0xA–0xF
CNT_W, $clog2(DEPTH+1), width of the fill-count output

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
code_valid  in  1  one-cycle strobe: code holds a new received byte
code  in  8  scan-code byte
enable  in  1  1 = decoded values are pushed; 0 = decode continues, no push
flush  in  1  synchronous: empty FIFO, clear overflow, FSM to IDLE
num_valid  out  1  FIFO head valid
num  out  4  FIFO head value
num_ready  in  1  consumer accepts head when num_valid and num_ready are both 1
count  out  CNT_W  entries held
overflow  out  1  sticky: a decoded value was dropped because the FIFO was full

Behaviour:
- Reset (rst high, asynchronous): FSM = IDLE, FIFO empty, num_valid = 0, num = 0, count = 0, overflow = 0.
- The FSM advances only on cycles with code_valid = 1.
- IDLE: E0 -> EXT; F0 -> BRK; any other byte (make, AA, FA, FE, E1) -> stay in IDLE.
- EXT: F0 -> EXT_BRK; E0 -> EXT; other -> IDLE.
- BRK: F0 -> BRK; E0 -> EXT (resync); other -> IDLE and decode the byte.
- EXT_BRK: F0/E0 -> stay; other -> IDLE; extended releases are discarded, with no decode.
- Top-row decode: 45=0, 16=1, 1E=2, 26=3, 25=4, 2E=5, 36=6, 3D=7, 3E=8, 46=9.
- Keypad decode (when KEYPAD_EN): 70=0, 69=1, 72=2, 7A=3, 6B=4, 73=5, 74=6, 6C=7, 75=8, 7D=9.
- Hex decode (when HEX_MODE): 1C=A, 32=B, 21=C, 23=D, 24=E, 2B=F.
- Unmapped bytes produce no push.
- Push condition: decode hit and enable = 1, in the same cycle as the terminating byte.
- Latency: terminating byte at edge N -> entry written at edge N, visible on num_valid/num after edge N.
- The FIFO is show-ahead: num always shows the head entry and is registered (no combinational path from code).
- Pop occurs when num_valid and num_ready are both 1; num/num_valid update at the same edge.
- Full with push and no pop: value dropped, overflow set to 1, count unchanged.
- Full with push and pop in the same cycle: both succeed, count unchanged, no overflow.
- Empty with pop request: ignored; num_valid stays 0.
- Pointers wrap modulo DEPTH; count = 0..DEPTH.
- flush has priority over push and pop in the same cycle; it does not reset num, only num_valid.
- overflow clears only on rst or flush.
- rst asserted mid-sequence (e.g. after F0): the FSM returns to IDLE, so the next byte is treated as a fresh make.

Decomposition:
- Package scan_pkg holds:
  - the FSM state enum (IDLE, EXT, BRK, EXT_BRK);
  - constants SC_BREAK = F0 and SC_EXT = E0;
  - a function decode_scan(byte, keypad_en, hex_mode) returning {hit, value[3:0]}.
- Sub-module sync_fifo (parameters WIDTH, DEPTH): push/pop/flush, full/empty/count, show-ahead head register.
- The top level contains the FSM, the decode call and overflow tracking.

Test Plan:
- Bytes 16, F0, 16 with enable = 1 and num_ready = 0 -> count = 1, num_valid = 1, num = 1 from the cycle after the second 16.
- Bytes E0, F0, 70 -> no push; then F0, 70 with KEYPAD_EN = 1 -> num = 0; with KEYPAD_EN = 0 -> no push.
- HEX_MODE = 1, bytes F0 1C then F0 2B -> FIFO holds A then F; pop both with num_ready = 1 -> num_valid drops after the second pop.
- DEPTH = 8: push 9 released digits with num_ready = 0 -> count = 8 and overflow = 1; the ninth is lost. Repeat at full with num_ready = 1 -> overflow not newly set and count stays 8.
- enable = 0, bytes F0 45 -> no push; enable = 1, bytes F0 46 -> num = 9. flush while holding 3 entries -> count = 0, num_valid = 0, overflow = 0.
- Byte F0, then rst pulse, then byte 26 -> no push; then F0 26 -> num = 3.
